sqr_pipe_sgn_uns: RTL and testbench

//   Pipelined squarer with a valid/ready stream interface. It handles unsigned
//   and two's-complement operands, selected per transaction.

---
 rtl/sqr_pipe_sgn_uns_if.sv | 22 ++
 rtl/sqr_pipe_sgn_uns.sv | 117 +++++++++++
 tb/tb_sqr_pipe_sgn_uns.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sqr_pipe_sgn_uns_if.sv
// Stream bundle for the pipelined squarer: operand side (X/TC) and result side (P).
interface sqr_pipe_sgn_uns_if #(
    parameter int width = 8
);
    logic                 TC;
    logic                 InValid;
    logic                 InReady;
    logic [width-1:0]     X;
    logic                 OutValid;
    logic                 OutReady;
    logic [2*width-1:0]   P;

    modport master (
        output TC, InValid, X, OutReady,
        input  InReady, OutValid, P
    );

    modport slave (
        input  TC, InValid, X, OutReady,
        output InReady, OutValid, P
    );
endinterface

// File: rtl/sqr_pipe_sgn_uns.sv
// Pipelined signed/unsigned squarer: folded partial products reduced in carry-save form,
// carried through elastic valid/ready stages; carry-propagate add feeds the last register.
module sqr_pipe_sgn_uns #(
    parameter int width  = 8,
    parameter int stages = 2
) (
    input logic               CLK,
    input logic               RST,
    sqr_pipe_sgn_uns_if.slave bus
);
    localparam int PW = 2 * width;

    logic [width-1:0] mag;
    logic [PW-1:0]    row;
    logic [PW-1:0]    nxt_s;
    logic [PW-1:0]    nxt_c;
    logic [PW-1:0]    in_sum;
    logic [PW-1:0]    in_car;

    // Each operand row i holds x(i) at column 2i and the folded pairs x(i)x(k), k>i, at i+k+1.
    always_comb begin
        mag    = (bus.TC && bus.X[width-1]) ? -bus.X : bus.X;
        row    = '0;
        nxt_s  = '0;
        nxt_c  = '0;
        in_sum = '0;
        in_car = '0;
        for (int i = 0; i < width; i++) begin
            row        = '0;
            row[2*i]   = mag[i];
            for (int k = i + 1; k < width; k++) begin
                row[i+k+1] = mag[i] & mag[k];
            end
            nxt_s  = in_sum ^ in_car ^ row;
            nxt_c  = ((in_sum & in_car) | (in_sum & row) | (in_car & row)) << 1;
            in_sum = nxt_s;
            in_car = nxt_c;
        end
    end

    logic              rdy_q, rdy_d;
    logic [stages-1:0] v_q, v_d;
    logic [stages-1:0] en;
    logic [stages-1:0] src_v;
    logic [PW-1:0]     sum_q   [stages];
    logic [PW-1:0]     sum_d   [stages];
    logic [PW-1:0]     car_q   [stages];
    logic [PW-1:0]     car_d   [stages];
    logic [PW-1:0]     src_sum [stages];
    logic [PW-1:0]     src_car [stages];
    logic              en_nxt;
    logic              in_ready;
    logic              in_fire;

    always_comb begin
        rdy_d  = 1'b1;
        en     = '0;
        en_nxt = bus.OutReady;
        for (int s = stages - 1; s >= 0; s--) begin
            en[s]  = ~v_q[s] | en_nxt;
            en_nxt = en[s];
        end
        in_ready = rdy_q & en[0];
        in_fire  = bus.InValid & in_ready;

        src_v      = '0;
        src_v[0]   = in_fire;
        src_sum[0] = in_sum;
        src_car[0] = in_car;
        for (int s = 1; s < stages; s++) begin
            src_v[s]   = v_q[s-1];
            src_sum[s] = sum_q[s-1];
            src_car[s] = car_q[s-1];
        end

        v_d = v_q;
        for (int s = 0; s < stages; s++) begin
            sum_d[s] = sum_q[s];
            car_d[s] = car_q[s];
            if (en[s]) begin
                v_d[s] = src_v[s];
                // Data only moves with a valid token, so idle X/TC never touch state.
                if (src_v[s]) begin
                    if (s == stages - 1) begin
                        sum_d[s] = src_sum[s] + src_car[s];
                        car_d[s] = '0;
                    end else begin
                        sum_d[s] = src_sum[s];
                        car_d[s] = src_car[s];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdy_q <= 1'b0;
            v_q   <= '0;
            for (int s = 0; s < stages; s++) begin
                sum_q[s] <= '0;
                car_q[s] <= '0;
            end
        end else begin
            rdy_q <= rdy_d;
            v_q   <= v_d;
            for (int s = 0; s < stages; s++) begin
                sum_q[s] <= sum_d[s];
                car_q[s] <= car_d[s];
            end
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = v_q[stages-1];
    assign bus.P        = sum_q[stages-1];
endmodule

// File: tb/tb_sqr_pipe_sgn_uns.sv
// Bench for sqr_pipe_sgn_uns: directed handshake/reset cases on a 2-stage copy, then
// exhaustive operands with random flow control on 1-, 2- and 5-stage copies.
module tb_sqr_pipe_sgn_uns;
    logic CLK;
    logic RST;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   go_rand = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_sq(input logic [7:0] x, input logic tc);
        int m;
        m = (tc && x[7]) ? 256 - int'(x) : int'(x);
        return m * m;
    endfunction

    sqr_pipe_sgn_uns_if #(.width(8)) db ();
    sqr_pipe_sgn_uns #(.width(8), .stages(2)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (db.slave)
    );

    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int STG = (g == 0) ? 1 : (g == 1) ? 2 : 5;
        bit done_g = 0;
        sqr_pipe_sgn_uns_if #(.width(8)) rb ();
        sqr_pipe_sgn_uns #(.width(8), .stages(STG)) u_dut (
            .CLK (CLK),
            .RST (RST),
            .bus (rb.slave)
        );

        initial begin
            int unsigned exp_q[$];
            int          idx;
            int          got;
            int          cyc;
            logic [8:0]  op;
            rb.InValid  = 1'b0;
            rb.OutReady = 1'b0;
            rb.X        = '0;
            rb.TC       = 1'b0;
            idx = 0;
            got = 0;
            cyc = 0;
            wait (go_rand);
            while (got < 512 && cyc < 20000) begin
                @(negedge CLK);
                rb.OutReady = ($urandom_range(0, 3) != 0);
                rb.InValid  = (idx < 512) && ($urandom_range(0, 3) != 0);
                if (rb.InValid) begin
                    op    = idx[8:0];
                    rb.X  = op[7:0];
                    rb.TC = op[8];
                end else begin
                    rb.X  = 8'($urandom);
                    rb.TC = 1'($urandom);
                end
                #1;
                if (rb.OutValid && rb.OutReady) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("rnd%0d_extra", STG), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("rnd%0d_p%0d", STG, got), 32'(rb.P), exp_q.pop_front());
                    end
                    got++;
                end
                if (rb.InValid && rb.InReady) begin
                    exp_q.push_back(ref_sq(rb.X, rb.TC));
                    idx++;
                end
                chk($sformatf("rnd%0d_capacity", STG), 32'(exp_q.size() <= STG), 32'd1);
                cyc++;
            end
            rb.InValid = 1'b0;
            chk($sformatf("rnd%0d_count", STG), 32'(got), 32'd512);
            done_g = 1;
        end
    end

    task automatic run_lat(input logic [7:0] x, input logic tc, input logic [15:0] exp, input string tag);
        db.InValid  = 1'b1;
        db.X        = x;
        db.TC       = tc;
        db.OutReady = 1'b1;
        #1;
        chk({tag, "_inready"}, 32'(db.InReady), 32'd1);
        @(posedge CLK); #1;
        db.InValid = 1'b0;
        chk({tag, "_early"}, 32'(db.OutValid), 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_valid"}, 32'(db.OutValid), 32'd1);
        chk({tag, "_p"}, 32'(db.P), 32'(exp));
    endtask

    initial begin
        int acc;
        int nout;
        int gap;
        int stale;
        bit started;
        bit all_done;

        RST         = 1'b1;
        db.InValid  = 1'b0;
        db.OutReady = 1'b0;
        db.X        = '0;
        db.TC       = 1'b0;
        @(posedge CLK); #2;
        chk("rst_outvalid", 32'(db.OutValid), 32'd0);
        chk("rst_p", 32'(db.P), 32'd0);
        chk("rst_inready", 32'(db.InReady), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rel_inready_pre", 32'(db.InReady), 32'd0);
        @(posedge CLK); #1;
        chk("rel_inready_post", 32'(db.InReady), 32'd1);

        run_lat(8'hFF, 1'b0, 16'hFE01, "u_ff");
        run_lat(8'h80, 1'b1, 16'h4000, "s_80");
        run_lat(8'hFF, 1'b1, 16'h0001, "s_ff");
        run_lat(8'h7F, 1'b1, 16'h3F01, "s_7f");
        run_lat(8'h81, 1'b1, 16'h3F01, "s_81");
        run_lat(8'h80, 1'b0, 16'h4000, "u_80");
        @(posedge CLK); #1;

        // Back-pressure: fill with OutReady low, then drain in order.
        db.OutReady = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            db.InValid = (acc < 5);
            db.X       = 8'(acc + 1);
            db.TC      = 1'b0;
            #1;
            if (db.InReady && db.InValid) acc++;
            @(posedge CLK); #1;
        end
        chk("fill_accepts", 32'(acc), 32'd2);
        chk("fill_inready", 32'(db.InReady), 32'd0);
        db.OutReady = 1'b1;
        nout    = 0;
        gap     = 0;
        started = 1'b0;
        for (int c = 0; c < 30 && nout < 5; c++) begin
            db.InValid = (acc < 5);
            db.X       = 8'(acc + 1);
            #1;
            if (db.OutValid) begin
                chk($sformatf("drain_p%0d", nout), 32'(db.P), 32'((nout + 1) * (nout + 1)));
                nout++;
                started = 1'b1;
            end else if (started) begin
                gap++;
            end
            if (db.InReady && db.InValid) acc++;
            @(posedge CLK); #1;
        end
        db.InValid = 1'b0;
        chk("drain_count", 32'(nout), 32'd5);
        chk("drain_gaps", 32'(gap), 32'd0);

        // Bubble collapse: a later operand fills the emptied first stage while output stalls.
        db.OutReady = 1'b0;
        db.InValid  = 1'b1;
        db.X        = 8'd3;
        #1;
        chk("bub_rdy1", 32'(db.InReady), 32'd1);
        @(posedge CLK); #1;
        db.InValid = 1'b0;
        @(posedge CLK); #1;
        db.InValid = 1'b1;
        db.X       = 8'd4;
        #1;
        chk("bub_rdy2", 32'(db.InReady), 32'd1);
        @(posedge CLK); #1;
        db.InValid = 1'b0;
        #1;
        chk("bub_full_rdy", 32'(db.InReady), 32'd0);
        chk("bub_full_valid", 32'(db.OutValid), 32'd1);
        chk("bub_p0", 32'(db.P), 32'd9);
        db.OutReady = 1'b1;
        @(posedge CLK); #1;
        chk("bub_p1_valid", 32'(db.OutValid), 32'd1);
        chk("bub_p1", 32'(db.P), 32'd16);
        @(posedge CLK); #1;
        chk("bub_empty", 32'(db.OutValid), 32'd0);

        // Asynchronous reset with two results in flight.
        db.OutReady = 1'b0;
        db.InValid  = 1'b1;
        db.X        = 8'd5;
        @(posedge CLK); #1;
        db.X = 8'd6;
        @(posedge CLK); #1;
        db.InValid = 1'b0;
        #1;
        chk("ar_loaded", 32'(db.OutValid), 32'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("ar_outvalid", 32'(db.OutValid), 32'd0);
        chk("ar_p", 32'(db.P), 32'd0);
        chk("ar_inready", 32'(db.InReady), 32'd0);
        @(negedge CLK);
        RST         = 1'b0;
        db.OutReady = 1'b1;
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (db.OutValid) stale++;
            @(posedge CLK);
        end
        #1;
        chk("ar_stale", 32'(stale), 32'd0);
        chk("ar_p_after", 32'(db.P), 32'd0);

        go_rand  = 1'b1;
        all_done = 1'b0;
        for (int c = 0; c < 25000 && !all_done; c++) begin
            @(posedge CLK);
            all_done = g_rnd[0].done_g && g_rnd[1].done_g && g_rnd[2].done_g;
        end
        chk("rnd_all_done", 32'(all_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
